// File: rtl/sv_rebuild_pkg.sv
// Shared defaults, per-element state encoding and the popcount helper for the
// 18-element DAC state-vector rebuilder.
package sv_rebuild_pkg;

   localparam int unsigned DefaultN       = 18;
   localparam int unsigned DefaultHoldMin = 4;
   localparam int unsigned DefaultHw      = 3;

   // 2'b11 is unused and recovers to StOff.
   typedef enum logic [1:0] {
      StOff  = 2'b00,
      StHold = 2'b01,
      StOn   = 2'b10
   } el_state_e;

   function automatic logic [4:0] popcount(input logic [DefaultN-1:0] v);
      logic [4:0] c;
      c = '0;
      for (int i = 0; i < DefaultN; i++) begin
         c = c + 5'(v[i]);
      end
      return c;
   endfunction

endpackage

// File: rtl/sv_rebuild_cell.sv
// One DAC element: OFF / HOLD / ON state machine with a minimum on-time counter
// and a sticky clear-pending flag.
module sv_rebuild_cell
   import sv_rebuild_pkg::*;
#(
   parameter int unsigned HOLD_MIN = DefaultHoldMin,
   parameter int unsigned HW       = DefaultHw
) (
   input  logic clk,
   input  logic rstn,
   input  logic clk_en,
   input  logic st,
   input  logic cl,
   output logic sv,
   output logic pend,
   output logic sv_next
);

   localparam logic [HW-1:0] Reload = HW'(HOLD_MIN - 1);

   el_state_e     state_q, state_d;
   logic [HW-1:0] cnt_q, cnt_d;
   logic          pend_q, pend_d;
   logic          sv_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      case (state_q)
         StOff: begin
            if (st) begin
               state_d = StHold;
               cnt_d   = Reload;
               pend_d  = cl;
            end
         end
         StHold: begin
            if (st) begin
               cnt_d  = Reload;
               pend_d = cl;
            end else if (cnt_q != '0) begin
               cnt_d  = cnt_q - 1'b1;
               pend_d = pend_q | cl;
            end else if (pend_q || cl) begin
               state_d = StOff;
               pend_d  = 1'b0;
            end else begin
               state_d = StOn;
            end
         end
         StOn: begin
            if (st) begin
               // A simultaneous clear re-arms and releases after the hold.
               state_d = StHold;
               cnt_d   = Reload;
               pend_d  = cl;
            end else if (cl) begin
               state_d = StOff;
            end
         end
         default: begin
            state_d = StOff;
            cnt_d   = '0;
            pend_d  = 1'b0;
         end
      endcase
   end

   assign sv_next = (state_d == StHold) || (state_d == StOn);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= StOff;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         sv_q    <= 1'b0;
      end else if (clk_en) begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         sv_q    <= sv_next;
      end
   end

   assign sv   = sv_q;
   assign pend = pend_q;

endmodule

// File: rtl/sv_rebuild18.sv
// Top level: N independent element cells plus the registered active-element count.
module sv_rebuild18
   import sv_rebuild_pkg::*;
#(
   parameter int unsigned N        = DefaultN,
   parameter int unsigned HOLD_MIN = DefaultHoldMin,
   parameter int unsigned HW       = DefaultHw
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         clk_en,
   input  logic [N-1:0] ST,
   input  logic [N-1:0] CL,
   output logic [N-1:0] SV,
   output logic [N-1:0] PEND,
   output logic [4:0]   ACT
);

   logic [N-1:0] sv_next;

   for (genvar i = 0; i < N; i++) begin : g_cell
      sv_rebuild_cell #(
         .HOLD_MIN (HOLD_MIN),
         .HW       (HW)
      ) u_cell (
         .clk     (clk),
         .rstn    (rstn),
         .clk_en  (clk_en),
         .st      (ST[i]),
         .cl      (CL[i]),
         .sv      (SV[i]),
         .pend    (PEND[i]),
         .sv_next (sv_next[i])
      );
   end

   // Counted from next-state so ACT and SV move on the same edge.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ACT <= '0;
      end else if (clk_en) begin
         ACT <= popcount(DefaultN'(sv_next));
      end
   end

endmodule

// File: tb/tb_sv_rebuild18.sv
// Self-checking bench: a HOLD_MIN=4 and a HOLD_MIN=1 instance against an
// expiry-time reference model, directed scenarios followed by random traffic.
module tb_sv_rebuild18;

   localparam int N = 18;
   localparam logic [N-1:0] ALL = 18'h3FFFF;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic         clk_en = 1'b0;
   logic [N-1:0] st = '0;
   logic [N-1:0] cl = '0;
   logic [N-1:0] sv_a, pend_a, sv_b, pend_b;
   logic [4:0]   act_a, act_b;

   int checks = 0;
   int errors = 0;

   // Model: each element is on until the first enabled edge at or after its
   // expiry edge where a clear is pending or requested.
   int hold_of [2] = '{4, 1};
   bit m_on   [2][N];
   bit m_pend [2][N];
   int m_exp  [2][N];
   int m_e    [2];

   sv_rebuild18 #(.N(N), .HOLD_MIN(4), .HW(3)) u_dut_a (
      .clk(clk), .rstn(rstn), .clk_en(clk_en), .ST(st), .CL(cl),
      .SV(sv_a), .PEND(pend_a), .ACT(act_a)
   );

   sv_rebuild18 #(.N(N), .HOLD_MIN(1), .HW(3)) u_dut_b (
      .clk(clk), .rstn(rstn), .clk_en(clk_en), .ST(st), .CL(cl),
      .SV(sv_b), .PEND(pend_b), .ACT(act_b)
   );

   always #5 clk = ~clk;

   function automatic void model_reset();
      for (int d = 0; d < 2; d++) begin
         m_e[d] = 0;
         for (int i = 0; i < N; i++) begin
            m_on[d][i] = 1'b0;
            m_pend[d][i] = 1'b0;
            m_exp[d][i] = 0;
         end
      end
   endfunction

   function automatic void model_edge(input logic [N-1:0] s, input logic [N-1:0] c);
      for (int d = 0; d < 2; d++) begin
         m_e[d]++;
         for (int i = 0; i < N; i++) begin
            if (s[i]) begin
               m_on[d][i] = 1'b1;
               m_exp[d][i] = m_e[d] + hold_of[d];
               m_pend[d][i] = c[i];
            end else if (m_on[d][i]) begin
               if (m_e[d] < m_exp[d][i]) begin
                  m_pend[d][i] = m_pend[d][i] | c[i];
               end else if (m_pend[d][i] || c[i]) begin
                  m_on[d][i] = 1'b0;
                  m_pend[d][i] = 1'b0;
               end
            end
         end
      end
   endfunction

   function automatic logic [N-1:0] model_sv(input int d);
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) v[i] = m_on[d][i];
      return v;
   endfunction

   function automatic logic [N-1:0] model_pend(input int d);
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) v[i] = m_pend[d][i];
      return v;
   endfunction

   task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [N-1:0] ea, eb;
      ea = model_sv(0);
      eb = model_sv(1);
      check({tag, " sv_a"}, sv_a, ea);
      check({tag, " pend_a"}, pend_a, model_pend(0));
      check({tag, " act_a"}, N'(act_a), N'($countones(ea)));
      check({tag, " sv_b"}, sv_b, eb);
      check({tag, " pend_b"}, pend_b, model_pend(1));
      check({tag, " act_b"}, N'(act_b), N'($countones(eb)));
   endtask

   task automatic step(input string tag, input logic [N-1:0] s, input logic [N-1:0] c,
                       input logic en);
      st = s;
      cl = c;
      clk_en = en;
      @(posedge clk);
      if (en && rstn) model_edge(s, c);
      #1;
      check_all(tag);
   endtask

   initial begin
      model_reset();
      #1;
      check_all("reset");
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;

      // Reset and idle.
      for (int k = 0; k < 10; k++) step("idle", '0, '0, 1'b1);

      // Set, then clear requested during hold.
      step("t2 e0", N'(1), '0, 1'b1);
      check("t2 sv0 set", N'(sv_a[0]), N'(1));
      step("t2 e1", '0, N'(1), 1'b1);
      check("t2 pend0", N'(pend_a[0]), N'(1));
      step("t2 e2", '0, '0, 1'b1);
      step("t2 e3", '0, '0, 1'b1);
      check("t2 sv0 held", N'(sv_a[0]), N'(1));
      step("t2 e4", '0, '0, 1'b1);
      check("t2 sv0 drop", N'(sv_a[0]), N'(0));
      check("t2 act0", N'(act_a), N'(0));

      // Free clear from ON.
      step("t3 e0", N'(1) << 5, '0, 1'b1);
      for (int k = 1; k < 6; k++) step("t3 wait", '0, '0, 1'b1);
      check("t3 sv5 on", N'(sv_a[5]), N'(1));
      step("t3 e6", '0, N'(1) << 5, 1'b1);
      check("t3 sv5 off", N'(sv_a[5]), N'(0));

      // Retrigger, then freeze mid-hold.
      step("t4 e0", N'(1) << 3, '0, 1'b1);
      step("t4 e1", '0, N'(1) << 3, 1'b1);
      step("t4 e2", N'(1) << 3, '0, 1'b1);
      check("t4 pend3 reload", N'(pend_a[3]), N'(0));
      step("t4 e3", '0, '0, 1'b1);
      for (int k = 0; k < 3; k++) step("t4 frozen", '0, N'(1) << 3, 1'b0);
      for (int k = 0; k < 4; k++) step("t4 resume", '0, '0, 1'b1);
      check("t4 sv3 on", N'(sv_a[3]), N'(1));
      step("t4 clear", '0, N'(1) << 3, 1'b1);

      // All elements set and cleared together.
      step("t5 set", ALL, ALL, 1'b1);
      check("t5 sv_b all", sv_b, ALL);
      check("t5 act_b 18", N'(act_b), N'(18));
      step("t5 next", '0, '0, 1'b1);
      check("t5 sv_b zero", sv_b, '0);
      for (int k = 0; k < 4; k++) step("t5 drain", '0, '0, 1'b1);

      // Asynchronous reset mid-hold.
      step("t6 set", ALL, '0, 1'b1);
      rstn = 1'b0;
      #1;
      model_reset();
      check_all("t6 async");
      check("t6 sv_a zero", sv_a, '0);
      @(negedge clk);
      rstn = 1'b1;
      step("t6 after", N'(1) << 7, '0, 1'b1);

      // Random traffic with occasional mid-cycle reset.
      for (int k = 0; k < 400; k++) begin
         logic [N-1:0] rs, rc;
         rs = N'($urandom & $urandom & $urandom);
         rc = N'($urandom & $urandom);
         step("rand", rs, rc, 1'($urandom_range(0, 3) != 0));
         if ($urandom_range(0, 99) == 0) begin
            rstn = 1'b0;
            #1;
            model_reset();
            check_all("rand reset");
            @(negedge clk);
            rstn = 1'b1;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sv_rebuild18.md
# sv_rebuild18

Rebuilds an 18-element DAC state vector from per-element set events and clear requests. It is the receiving end of the rising-transition stream produced by the 18-input transition detector: each set pulse turns an element on, and each clear request turns it off. Every element has a minimum on-time so that its driver can settle. The block sits between the transition/event path and the element drivers of the DAC digital section.

## Interface
Parameters:
- N, 18, number of elements.
- HOLD_MIN, 4, minimum on-time in enabled cycles; legal range 1 to 2^HW−1.
- HW, 3, width of the hold counter.

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- rstn, input, 1, asynchronous active-low reset.
- clk_en, input, 1, cycle enable; when 0, all state is frozen.
- ST, input, N, set pulses, normally the transition vector from the detector.
- CL, input, N, clear requests.
- SV, output, N, registered state vector driving the elements.
- PEND, output, N, registered clear-pending flags, used for observability.
- ACT, output, 5, registered count of active elements; always equals popcount(SV).

## Operation
- Each element i runs an independent FSM with three states:
  - OFF: SV[i]=0.
  - HOLD: SV[i]=1 and the hold counter cnt[i] is running.
  - ON: SV[i]=1 and the element is free to clear.
- Reset forces every element to OFF, with cnt=0, PEND=0, SV=0 and ACT=0.
- State advances only on edges where clk_en=1. Edges with clk_en=0 keep every register unchanged, ACT included.
- OFF:
  - ST[i]=1 moves the element to HOLD, loads cnt=HOLD_MIN−1 and sets PEND[i]=CL[i].
  - CL[i] alone is ignored.
- HOLD:
  - ST[i]=1 retriggers: cnt reloads to HOLD_MIN−1, PEND[i] takes the value CL[i], and the element stays in HOLD.
  - Otherwise, if cnt≠0: cnt decrements, and CL[i]=1 sets PEND[i]. PEND is sticky until the element leaves HOLD.
  - Otherwise, if cnt=0: when PEND[i] or CL[i] is set, the element goes to OFF and PEND clears. When neither is set, it goes to ON.
- ON:
  - CL[i]=1 with ST[i]=0 goes to OFF.
  - ST[i]=1 goes to HOLD with a counter reload and PEND[i]=CL[i], so a simultaneous set and clear re-arms the element and then releases it after the hold.
  - Neither input set: the element stays ON.
- ACT is registered from the popcount of next-state SV, so ACT and SV change on the same edge. The arithmetic is unsigned, and the maximum of 18 fits in 5 bits.
- Elements do not interact, apart from contributing to ACT.

## Timing
- Set latency is one enabled edge: ST[i] sampled at edge k gives SV[i]=1 after edge k.
- Minimum high time is exactly HOLD_MIN enabled cycles. A clear requested at any time during the hold drops SV[i] after edge k+HOLD_MIN.
- Clear latency in ON is one enabled edge.
- With HOLD_MIN=1, a simultaneous ST and CL gives SV high for exactly one enabled cycle.
- Boundary cases:
  - clk_en low mid-hold: the count pauses and resumes without loss.
  - rstn asserted mid-hold: SV, PEND and ACT are 0 immediately (asynchronous), and no pending clear survives reset.
  - rstn deasserting: the first edge with rstn=1 is evaluated normally.
- No combinational path from any input to any output.

## Structure
- Package sv_rebuild_pkg holds:
  - N, HOLD_MIN and HW defaults.
  - The state enum: OFF=2'b00, HOLD=2'b01, ON=2'b10. Encoding 2'b11 is illegal and recovers to OFF.
  - A popcount function.
- Sub-module sv_rebuild_cell contains one element FSM (state, cnt, PEND bit) and is instantiated N times by generate.
- The top level contains only the generate loop and the ACT register.

## Test plan
- Reset and idle: rstn=0 then 1 with ST=CL=0 for 10 cycles → SV=0, PEND=0, ACT=0 throughout.
- Set, then clear in HOLD: ST=18'h00001 for one cycle at edge 0, then CL[0]=1 at edge 1 → SV[0]=1 after edges 0–3, PEND[0]=1 after edge 1, SV[0]=0 after edge 4, ACT goes 1 then 0.
- Free clear: ST[5] pulse at edge 0, then CL[5] at edge 6 → the element is in ON from edge 4, SV[5] falls after edge 6, PEND[5] stays 0.
- Retrigger and freeze: ST[3] at edges 0 and 2, CL[3] at edge 1, and clk_en=0 for 3 cycles after edge 3 → PEND[3] is cleared by the reload at edge 2, SV[3] stays high, the hold ends 4 enabled edges after edge 2, and the element reaches ON.
- All elements with simultaneous set and clear, HOLD_MIN=1 build: ST=CL=18'h3FFFF for one cycle → SV=18'h3FFFF and ACT=18 for one enabled cycle, then SV=0 and ACT=0.
- Asynchronous reset mid-hold: ST=18'h3FFFF, then rstn=0 between edges → SV, PEND and ACT are 0 before the next clk edge.
